// File: rtl/usb_pkg.sv
// Shared types and constants for the USB endpoint buffer controller.
package usb_pkg;

  localparam int BUF_DEPTH  = 64;
  localparam int BUF_ADDR_W = 6;
  localparam int BUF_OCC_W  = 7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_WR   = 3'd1,
    TX_RD   = 3'd2,
    HOST_WR = 3'd3,
    HOST_RD = 3'd4,
    CLEAR   = 3'd5
  } buf_state_t;

  function automatic logic is_read(input buf_state_t s);
    return (s == TX_RD) || (s == HOST_RD);
  endfunction

  function automatic logic is_write(input buf_state_t s);
    return (s == RX_WR) || (s == HOST_WR);
  endfunction

endpackage

// File: rtl/usb_buffer_mem.sv
// Endpoint buffer storage: register file with synchronous write and a
// registered, write-first read port. The array itself is not reset.
module usb_buffer_mem
  import usb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = BUF_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // A read of the slot being written in the same cycle returns the new byte,
  // so a write immediately followed by a read of a just-emptied buffer works.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/usb_buffer_ctrl.sv
// Endpoint buffer controller: pointers, occupancy and one-access-per-cycle
// arbitration between USB RX, USB TX and the AHB host side.
module usb_buffer_ctrl
  import usb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = BUF_ADDR_W,
  parameter int OCC_W  = BUF_OCC_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flush,
  input  logic              store_rx_packet_data,
  input  logic [DATA_W-1:0] rx_packet_data,
  input  logic              get_tx_packet_data,
  output logic [DATA_W-1:0] tx_packet_data,
  input  logic              host_clear,
  input  logic              host_wreq,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_rreq,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic [OCC_W-1:0]  buffer_occupancy,
  output logic              buffer_error,
  output logic [2:0]        state_dbg
);

  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(1 << ADDR_W);
  localparam logic [OCC_W-1:0]  OCC_ONE  = OCC_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  buf_state_t        state, next_state;
  logic [ADDR_W-1:0] rptr, wptr;
  logic              pend_rx, pend_tx, host_hold;
  logic [DATA_W-1:0] rx_data_q;
  logic              clear_req, full, empty, host_mask;
  logic              rx_busy, tx_busy, rx_new, tx_new, rx_drop, tx_drop;
  logic              rx_req, tx_req;
  logic              mem_wr_en, mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_wr_data, mem_rd_data;

  assign state_dbg = state;
  assign clear_req = flush | host_clear;
  assign full      = (buffer_occupancy == OCC_FULL);
  assign empty     = (buffer_occupancy == '0);

  // An RX/TX pulse is "outstanding" from the pulse until its access cycle ends;
  // a further pulse in that window is lost and flagged. A clear swallows pulses.
  assign rx_busy = pend_rx | (state == RX_WR);
  assign tx_busy = pend_tx | (state == TX_RD);
  assign rx_new  = store_rx_packet_data & ~clear_req & ~rx_busy;
  assign tx_new  = get_tx_packet_data   & ~clear_req & ~tx_busy;
  assign rx_drop = store_rx_packet_data & ~clear_req & rx_busy;
  assign tx_drop = get_tx_packet_data   & ~clear_req & tx_busy;
  assign rx_req  = pend_rx | rx_new;
  assign tx_req  = pend_tx | tx_new;

  // Host handshake: a request (wreq/rreq) is held high until host_ack, which
  // pulses for exactly the one cycle in which the access is performed; the host
  // drops the request the following cycle, so requests seen in the ack cycle or
  // the cycle after it are ignored rather than granted twice.
  assign host_mask = host_hold | (state == HOST_WR) | (state == HOST_RD);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    if (clear_req)                   next_state = CLEAR;
    else if (rx_req)                 next_state = RX_WR;
    else if (tx_req)                 next_state = TX_RD;
    else if (host_wreq && !host_mask) next_state = HOST_WR;
    else if (host_rreq && !host_mask) next_state = HOST_RD;
  end

  // The read is issued one cycle ahead, during arbitration, so the byte is on
  // the memory output throughout the read state; the address accounts for a
  // pointer update landing at the same edge.
  always_comb begin
    host_ack    = (state == HOST_WR) || (state == HOST_RD);
    mem_wr_en   = is_write(state) && !full;
    mem_wr_data = (state == HOST_WR) ? host_wdata : rx_data_q;
    mem_rd_en   = is_read(next_state);
    mem_rd_addr = rptr;
    if (state == CLEAR)                 mem_rd_addr = '0;
    else if (is_read(state) && !empty)  mem_rd_addr = rptr + PTR_ONE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_rx   <= 1'b0;
      pend_tx   <= 1'b0;
      host_hold <= 1'b0;
      rx_data_q <= '0;
    end else begin
      host_hold <= host_ack;
      if (rx_new) rx_data_q <= rx_packet_data;
      if (clear_req) begin
        pend_rx <= 1'b0;
        pend_tx <= 1'b0;
      end else begin
        if (next_state == RX_WR) pend_rx <= 1'b0;
        else if (rx_new)         pend_rx <= 1'b1;
        if (next_state == TX_RD) pend_tx <= 1'b0;
        else if (tx_new)         pend_tx <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rptr             <= '0;
      wptr             <= '0;
      buffer_occupancy <= '0;
      buffer_error     <= 1'b0;
      tx_packet_data   <= '0;
      host_rdata       <= '0;
    end else begin
      case (state)
        CLEAR: begin
          rptr             <= '0;
          wptr             <= '0;
          buffer_occupancy <= '0;
          buffer_error     <= 1'b0;
        end
        RX_WR, HOST_WR: begin
          if (full) buffer_error <= 1'b1;
          else begin
            wptr             <= wptr + PTR_ONE;
            buffer_occupancy <= buffer_occupancy + OCC_ONE;
          end
        end
        TX_RD, HOST_RD: begin
          if (empty) buffer_error <= 1'b1;
          else begin
            rptr             <= rptr + PTR_ONE;
            buffer_occupancy <= buffer_occupancy - OCC_ONE;
            if (state == TX_RD) tx_packet_data <= mem_rd_data;
            else                host_rdata     <= mem_rd_data;
          end
        end
        default: ;
      endcase
      if (rx_drop || tx_drop) buffer_error <= 1'b1;
    end
  end

  usb_buffer_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (wptr),
    .wr_data (mem_wr_data),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rd_data)
  );

endmodule

// File: doc/usb_buffer_ctrl.md
Name: usb_buffer_ctrl

Overview:
Controller and arbiter for the USB endpoint data buffer, shared by the USB receiver (stores received bytes, flushes), the USB transmitter (fetches bytes to send) and the AHB host side (writes TX payload, reads RX payload). It owns the read/write pointers, the occupancy count and one-access-per-cycle arbitration. Storage lives in a sub-module register file. It produces the `buffer_occupancy` value consumed by the receiver and transmitter control units.

Parameters:
DATA_W, 8, byte width of each buffer entry
ADDR_W, 6, pointer width; DEPTH = 2**ADDR_W = 64 entries
OCC_W, 7, occupancy width (ADDR_W+1, counts 0..64)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
flush  in  1  RX flush pulse: empty the buffer
store_rx_packet_data  in  1  RX write pulse
rx_packet_data  in  DATA_W  RX write data
get_tx_packet_data  in  1  TX read pulse
tx_packet_data  out  DATA_W  TX read data
host_clear  in  1  host flush pulse: empty the buffer
host_wreq  in  1  host write request, held until host_ack
host_wdata  in  DATA_W  host write data
host_rreq  in  1  host read request, held until host_ack
host_rdata  out  DATA_W  host read data
host_ack  out  1  one-cycle grant pulse for the host request
buffer_occupancy  out  OCC_W  entries currently stored
buffer_error  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (async, n_rst=0):
  - rptr=0, wptr=0, buffer_occupancy=0.
  - pend_rx=0, pend_tx=0.
  - tx_packet_data=0, host_rdata=0, host_ack=0, buffer_error=0.
  - FSM=IDLE. Memory contents are don't-care.
- Pending latches:
  - A store_rx_packet_data or get_tx_packet_data pulse sets pend_rx / pend_tx on the next edge (RX data captured with it).
  - The latch clears when its access is granted.
  - A new pulse while still pending is dropped and sets buffer_error.
- Single-port memory: exactly one access per cycle.
- Fixed priority per cycle:
  1. flush or host_clear
  2. pend_rx
  3. pend_tx
  4. host_wreq
  5. host_rreq
- FSM states IDLE, RX_WR, TX_RD, HOST_WR, HOST_RD, CLEAR:
  - Each state lasts exactly one cycle; the next state is chosen by priority from the current requests, else IDLE.
  - Back-to-back grants are allowed.
- CLEAR:
  - rptr=wptr=0, occupancy=0, buffer_error=0.
  - pend_rx and pend_tx are discarded.
  - A host request in flight is not acked and must be re-arbitrated.
- RX_WR / HOST_WR:
  - Not full: mem[wptr]<=data, wptr+1 (wraps 63->0), occupancy+1.
  - Full (64): write dropped, pointers unchanged, buffer_error=1.
- TX_RD / HOST_RD:
  - Not empty: data<=mem[rptr] registered onto tx_packet_data / host_rdata, rptr+1 with wrap, occupancy-1.
  - Empty: output holds its previous value, buffer_error=1.
- Latency:
  - Host: host_ack asserts in the grant cycle; host_rdata is valid the cycle after host_ack and holds until the next host read.
  - TX: tx_packet_data is valid at most 3 cycles after the get pulse (latch, arbitration, registered read). The TX side must not sample earlier.
- Host protocol: the host deasserts its request the cycle after host_ack. A request still high 2 cycles after ack counts as a new request.
- Simultaneous host_wreq and host_rreq: the write is served first.
- Simultaneous flush/clear with any pulse: clear wins and the pulse is discarded.
- Occupancy is exact: it never exceeds 64 and never underflows.
- Mid-operation reset: all state returns to the reset values immediately.

Decomposition:
- Shared package `usb_pkg` holds:
  - typedef `buf_state_t` (the six FSM states)
  - constants BUF_DEPTH=64, BUF_ADDR_W=6, BUF_OCC_W=7
- Sub-module `usb_buffer_mem`:
  - 64x8 register file, synchronous write.
  - Registered read: one read port and one write port, with enables driven by usb_buffer_ctrl.
  - No reset on the storage array.

Test Plan:
1. Reset then idle -> buffer_occupancy=0, buffer_error=0, host_ack=0. Host holds host_rreq -> host_ack pulses, buffer_error=1, host_rdata stays 0.
2. 64 RX store pulses spaced 8 cycles apart (data 0x00..0x3F), then a 65th pulse -> occupancy=64, buffer_error=1. Then 64 TX gets -> tx_packet_data sequence 0x00..0x3F, occupancy=0.
3. Host writes 0xA5, 0x5A; host_wreq and host_rreq asserted together -> the write is acked first. The read then returns 0xA5 one cycle after its ack, occupancy=1.
4. Same-cycle store_rx_packet_data (0x11) and host_wreq (0x22) -> RX granted first, host_ack one cycle later. Host reads return 0x11 then 0x22.
5. Fill to 10 entries, pulse flush together with get_tx_packet_data -> occupancy=0, pointers 0, buffer_error cleared, no TX read performed. A subsequent write lands at address 0.
6. Write 40, read 40, write 40, read 40 -> pointers wrap past 63 and all data matches. Assert n_rst mid-sequence -> all outputs return to reset values in the same cycle.
